// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the combinational IM,
// qualifies the returned word, and handles stall, redirect, halt/resume
// and misaligned redirect targets.
module im_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'h0000_0073,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    input  logic             resume,
    output logic [31:0]      im_address,
    input  logic [31:0]      im_instruction,
    output logic [31:0]      instr_out,
    output logic [31:0]      pc_out,
    output logic             instr_valid,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned XLEN    = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [XLEN-1:0]  pc, pc_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    // State, PC and fetch counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BOOT;
            pc    <= RESET_PC;
            cnt   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic; redirect outranks stall, misalignment outranks all
    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = cnt;
        unique case (state)
            ST_BOOT: begin
                state_n = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
                    state_n = ST_ERROR;
                end else if (redirect_valid) begin
                    pc_n = redirect_target;
                    if (!stall) begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else if (stall) begin
                    pc_n = pc;
                end else if (im_instruction == HALT_INSTR) begin
                    state_n = ST_HALT;
                    cnt_n   = cnt + CNT_W'(1);
                end else begin
                    pc_n  = pc + STEP;
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_n = ST_RUN;
                    pc_n    = pc + STEP;
                end
            end
            ST_ERROR: begin
                state_n = ST_ERROR;
            end
            default: begin
                state_n = ST_BOOT;
            end
        endcase
    end

    // Outputs decoded from registered state plus the IM return word
    always_comb begin
        im_address   = pc;
        pc_out       = pc;
        instr_valid  = (state == ST_RUN);
        instr_out    = (state == ST_RUN) ? im_instruction : NOP;
        halted       = (state == ST_HALT);
        misalign_err = (state == ST_ERROR);
        instr_count  = cnt;
    end

endmodule

// File: doc/im_fetch_ctrl.md
Name: im_fetch_ctrl

Overview:
Instruction-fetch sequencer in front of the combinational instruction memory (IM: address in, instruction out, word-addressed by byte address). It owns the program counter and drives the IM address. It qualifies the returned instruction with a valid flag, handles stall, branch/jump redirect, halt-on-instruction and resume. It also detects misaligned redirect targets and keeps a fetched-instruction counter for debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned
HALT_INSTR, 32'h0000_0073, encoding (ECALL) that stops fetch when accepted
CNT_W, 32, width of fetched-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  hold current PC/instruction (downstream not ready)
redirect_valid  input  1  load redirect_target as next PC (taken branch/jump)
redirect_target  input  32  next PC on redirect
resume  input  1  single-cycle pulse; leaves HALT
im_address  output  32  byte address to IM; equals pc
im_instruction  input  32  instruction word from IM (combinational, same cycle)
instr_out  output  32  instruction to decode; equals im_instruction when instr_valid else 32'h0000_0013 (NOP)
pc_out  output  32  PC of instr_out
instr_valid  output  1  instr_out is a real fetched instruction
halted  output  1  state == HALT
misalign_err  output  1  sticky; state == ERROR
instr_count  output  CNT_W  number of accepted instructions, wraps

Behaviour:
- States: BOOT, RUN, HALT, ERROR. State, pc and instr_count are registers. All other outputs are combinational from them plus im_instruction.
- Reset (async, any time, including mid-stall/halt): state=BOOT, pc=RESET_PC, instr_count=0. Outputs: im_address=pc_out=RESET_PC, instr_valid=0, instr_out=NOP, halted=0, misalign_err=0.
- BOOT: lasts exactly one cycle after rst deasserts, with instr_valid=0. Next state is RUN with pc unchanged, so the first valid fetch is at RESET_PC on the 2nd edge after reset release. Inputs are ignored in BOOT.
- RUN: instr_valid=1. "Accepted" means RUN && !stall. Per clock edge, in priority order:
  1. redirect_valid with redirect_target[1:0]!=0 -> ERROR, pc holds. Applies even when stall=1.
  2. redirect_valid, aligned -> pc=redirect_target. Redirect overrides stall. instr_count increments only if stall=0.
  3. stall=1 -> pc and instr_count hold. The instruction stays presented.
  4. im_instruction==HALT_INSTR -> HALT, pc holds at the halt address, instr_count+1.
  5. otherwise pc=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), instr_count+1.
- HALT: instr_valid=0, halted=1, pc held.
  - resume=1 -> RUN with pc=pc+4.
  - redirect_valid and stall are ignored. resume during stall still applies.
- ERROR: instr_valid=0, misalign_err=1, pc frozen. The only exit is rst. resume and redirect are ignored.
- instr_count wraps from all-ones to 0 without flagging.
- There is no internal latency beyond the PC register: im_address changes only on clock edges or async reset.

Test Plan:
- Reset/boot: assert rst mid-run at pc=0x10, release -> one cycle with instr_valid=0, pc_out=0. Next cycle instr_valid=1 and IM words at 0,4,8,12 appear on successive cycles; instr_count=4 after 4 accepted.
- Stall: stall=1 for 3 cycles at pc=8 -> pc_out stays 8, instr_out constant, instr_count frozen. Release -> pc=12 next edge.
- Redirect: at pc=4 pulse redirect_valid with target 0x20 -> next pc_out=0x20. With stall=1 also asserted, pc still becomes 0x20 and instr_count does not increment.
- Halt/resume: IM word 0x00000073 at address 0x18 -> after acceptance halted=1, instr_valid=0, pc_out=0x18. Redirect to 0x40 is ignored. Pulse resume -> RUN at pc=0x1C.
- Misalign: redirect_target=0x22 -> misalign_err=1, pc frozen at the prior value, resume ignored. rst clears it back to BOOT.
- Wrap: redirect to 0xFFFF_FFFC, accept one instruction -> pc=0x0000_0000 with no error.
